// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: fetch, decode, memory, ALU and branch sequencing.
// Optional JAL support is compiled in when MULTICYCLE_CONTROL_JAL_EN is defined.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ILLEGAL = 4'd9
`ifdef MULTICYCLE_CONTROL_JAL_EN
    , S_JAL   = 4'd10
`endif
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef MULTICYCLE_CONTROL_JAL_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R:          state <= S_EXEC_R;
            OP_LW, OP_SW:  state <= S_MEMADR;
            OP_BEQ:        state <= S_BEQ;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            OP_JAL:        state <= S_JAL;
`endif
            default:       state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC_R: state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BEQ:    state <= S_FETCH;
        S_ILLEGAL: state <= S_ILLEGAL;
`ifdef MULTICYCLE_CONTROL_JAL_EN
        S_JAL:    state <= S_ALUWB;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state; only mem_ready and zero reach them combinationally.
  // Reset forces everything quiet even before the first edge has settled state.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state_o    = rst ? S_FETCH : state;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          addr_src   = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_ILLEGAL: illegal = 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle check of every output plus state_o.
// JAL expectations follow MULTICYCLE_CONTROL_JAL_EN the same way the design does.
module tb_multicycle_control;

  localparam logic [3:0] ST_F  = 4'd0, ST_D  = 4'd1, ST_MA = 4'd2, ST_MR = 4'd3,
                         ST_WB = 4'd4, ST_WR = 4'd5, ST_EX = 4'd6, ST_AW = 4'd7,
                         ST_BQ = 4'd8, ST_IL = 4'd9, ST_J  = 4'd10;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_done, illegal;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, instr_done, illegal, state_o};

  function automatic logic [19:0] mk(input logic [3:0] st, input logic mreq, we, asrc,
                                     irw, pcw, rw, input logic [1:0] sa, sb, op, rs,
                                     input logic done, ill);
    return {mreq, we, asrc, irw, pcw, rw, sa, sb, op, rs, done, ill, st};
  endfunction

  // Driver: apply inputs mid-cycle, compare against the queued expectation, advance one cycle.
  task automatic step(input string tag, input logic rdy, input logic z, input logic [19:0] exp);
    logic [19:0] e;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(negedge clk);
  endtask

  logic [19:0] v_zero, v_fwait, v_fgo, v_dec, v_madr, v_mrd, v_mwb, v_mwr_wait, v_mwr_go;
  logic [19:0] v_exr, v_aluwb, v_beq_t, v_beq_n, v_ill, v_jal;

  initial begin
    v_zero     = mk(ST_F,  0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
    v_fwait    = mk(ST_F,  1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
    v_fgo      = mk(ST_F,  1,0,0,1,1,0, 2'b00,2'b01,2'b00,2'b10, 0,0);
    v_dec      = mk(ST_D,  0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0);
    v_madr     = mk(ST_MA, 0,0,0,0,0,0, 2'b10,2'b10,2'b00,2'b00, 0,0);
    v_mrd      = mk(ST_MR, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
    v_mwb      = mk(ST_WB, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 1,0);
    v_mwr_wait = mk(ST_WR, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
    v_mwr_go   = mk(ST_WR, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
    v_exr      = mk(ST_EX, 0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
    v_aluwb    = mk(ST_AW, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
    v_beq_t    = mk(ST_BQ, 0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 1,0);
    v_beq_n    = mk(ST_BQ, 0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0);
    v_ill      = mk(ST_IL, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1);
    v_jal      = mk(ST_J,  0,0,0,0,1,0, 2'b01,2'b01,2'b00,2'b00, 0,0);

    rst = 1'b1; opcode = 7'b0110011; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    step("reset_a", 1, 1, v_zero);
    step("reset_b", 1, 0, v_zero);
    rst = 1'b0;

    // R-type, zero-wait memory
    step("r_fetch", 1, 0, v_fgo);
    step("r_decode", 1, 0, v_dec);
    step("r_exec", 1, 0, v_exr);
    step("r_aluwb", 1, 0, v_aluwb);

    // LW with two wait cycles in MEMRD
    opcode = 7'b0000011;
    step("lw_fetch", 1, 0, v_fgo);
    step("lw_decode", 0, 0, v_dec);
    step("lw_memadr", 1, 0, v_madr);
    step("lw_memrd_w0", 0, 0, v_mrd);
    step("lw_memrd_w1", 0, 1, v_mrd);
    step("lw_memrd_go", 1, 0, v_mrd);
    step("lw_memwb", 1, 0, v_mwb);

    // BEQ taken then not taken
    opcode = 7'b1100011;
    step("beq1_fetch", 1, 0, v_fgo);
    step("beq1_decode", 1, 0, v_dec);
    step("beq1_exec", 1, 1, v_beq_t);
    step("beq0_fetch", 1, 1, v_fgo);
    step("beq0_decode", 1, 1, v_dec);
    step("beq0_exec", 1, 0, v_beq_n);

    // SW with a fetch wait, zero-wait store
    opcode = 7'b0100011;
    step("sw_fetch_wait", 0, 0, v_fwait);
    step("sw_fetch", 1, 0, v_fgo);
    step("sw_decode", 1, 0, v_dec);
    step("sw_memadr", 1, 0, v_madr);
    step("sw_memwr", 1, 0, v_mwr_go);

    // SW interrupted by reset while waiting in MEMWR
    step("swr_fetch", 1, 0, v_fgo);
    step("swr_decode", 1, 0, v_dec);
    step("swr_memadr", 0, 0, v_madr);
    step("swr_memwr_wait", 0, 0, v_mwr_wait);
    rst = 1'b1;
    step("swr_in_reset", 1, 0, v_zero);
    step("swr_in_reset2", 1, 0, v_zero);
    rst = 1'b0;
    step("swr_post_reset", 0, 0, v_fwait);
    step("swr_refetch", 1, 0, v_fgo);

    // Unsupported opcode traps and stays trapped until reset
    opcode = 7'b0010011;
    step("ill_decode", 1, 0, v_dec);
    for (int i = 0; i < 10; i++) step("ill_hold", i[0], i[1], v_ill);
    rst = 1'b1;
    step("ill_reset", 1, 0, v_zero);
    rst = 1'b0;
    step("ill_post_reset", 0, 0, v_fwait);

    // JAL opcode
    opcode = 7'b1101111;
    step("jal_fetch", 1, 0, v_fgo);
    step("jal_decode", 1, 0, v_dec);
`ifdef MULTICYCLE_CONTROL_JAL_EN
    step("jal_exec", 1, 0, v_jal);
    step("jal_aluwb", 1, 0, v_aluwb);
    step("jal_next_fetch", 0, 0, v_fwait);
`else
    step("jal_illegal", 1, 0, v_ill);
    step("jal_illegal_hold", 0, 0, v_ill);
    rst = 1'b1;
    step("jal_reset", 1, 0, v_zero);
    rst = 1'b0;
    step("jal_post_reset", 0, 0, v_fwait);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
